// File: rtl/calc2_req_issuer_if.sv
`default_nettype none
// =============================================================================
// Module   : calc2_req_issuer_if
// Brief    : Operation, request, response and result bundle of one calc2 port.
// Revision : 1.0
// =============================================================================
interface calc2_req_issuer_if;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op_cmd;
  logic [31:0] op_a;
  logic [31:0] op_b;

  logic [3:0]  req_cmd_out;
  logic [31:0] req_data_out;
  logic [1:0]  req_tag_out;

  logic [1:0]  resp_in;
  logic [31:0] resp_data_in;
  logic [1:0]  resp_tag_in;

  logic        res_valid;
  logic [1:0]  res_resp;
  logic [31:0] res_data;
  logic [1:0]  res_tag;
  logic [3:0]  res_cmd;
  logic        spurious_err;
  logic        timeout_err;
  logic [1:0]  timeout_tag;
  logic [3:0]  busy_tags;

  modport slave (
    input  op_valid, op_cmd, op_a, op_b, resp_in, resp_data_in, resp_tag_in,
    output op_ready, req_cmd_out, req_data_out, req_tag_out,
           res_valid, res_resp, res_data, res_tag, res_cmd,
           spurious_err, timeout_err, timeout_tag, busy_tags
  );

  modport master (
    output op_valid, op_cmd, op_a, op_b, resp_in, resp_data_in, resp_tag_in,
    input  op_ready, req_cmd_out, req_data_out, req_tag_out,
           res_valid, res_resp, res_data, res_tag, res_cmd,
           spurious_err, timeout_err, timeout_tag, busy_tags
  );
endinterface
`default_nettype wire

// File: rtl/calc2_req_issuer.sv
`default_nettype none
// =============================================================================
// Module   : calc2_req_issuer
// Brief    : Serializes operations onto the two-cycle calc2 request protocol,
//            allocates/retires the four tags and matches returning responses.
// Revision : 1.0
// =============================================================================
module calc2_req_issuer #(
  parameter int TIMEOUT = 64
) (
  input  wire logic         c_clk,
  input  wire logic         reset,
  calc2_req_issuer_if.slave bus
);
  localparam logic [7:0] AGE_MAX = 8'(TIMEOUT - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, OP2 = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [3:0]  inuse_q, inuse_d;
  logic [3:0]  cmd_mem_q [4];
  logic [3:0]  cmd_mem_d [4];
  logic [7:0]  age_q [4];
  logic [7:0]  age_d [4];
  logic [31:0] opb_q, opb_d;

  logic [3:0]  req_cmd_q, req_cmd_d;
  logic [31:0] req_data_q, req_data_d;
  logic [1:0]  req_tag_q, req_tag_d;
  logic        res_valid_q, res_valid_d;
  logic [1:0]  res_resp_q, res_resp_d;
  logic [31:0] res_data_q, res_data_d;
  logic [1:0]  res_tag_q, res_tag_d;
  logic [3:0]  res_cmd_q, res_cmd_d;
  logic        spurious_q, spurious_d;
  logic        tout_q, tout_d;
  logic [1:0]  tout_tag_q, tout_tag_d;

  logic        ready;
  logic        accept;
  logic        resp_hit;
  logic [1:0]  free_tag;
  logic        exp_any;
  logic [1:0]  exp_tag;

  assign ready    = (state_q == IDLE) && (inuse_q != 4'hF);
  assign accept   = bus.op_valid && ready && (bus.op_cmd != 4'd0);
  assign resp_hit = (bus.resp_in != 2'd0) && inuse_q[bus.resp_tag_in];

  always_comb begin
    state_d     = state_q;
    inuse_d     = inuse_q;
    cmd_mem_d   = cmd_mem_q;
    age_d       = age_q;
    opb_d       = opb_q;
    req_cmd_d   = 4'd0;
    req_data_d  = 32'd0;
    req_tag_d   = 2'd0;
    res_valid_d = 1'b0;
    res_resp_d  = 2'd0;
    res_data_d  = 32'd0;
    res_tag_d   = 2'd0;
    res_cmd_d   = 4'd0;
    spurious_d  = 1'b0;
    tout_d      = 1'b0;
    tout_tag_d  = 2'd0;
    free_tag    = 2'd0;
    exp_any     = 1'b0;
    exp_tag     = 2'd0;

    // Descending scans leave the lowest qualifying index in the result.
    for (int i = 3; i >= 0; i--) begin
      if (!inuse_q[i]) free_tag = 2'(i);
      if (inuse_q[i] && (age_q[i] == AGE_MAX) &&
          !(resp_hit && (bus.resp_tag_in == 2'(i)))) begin
        exp_any = 1'b1;
        exp_tag = 2'(i);
      end
    end

    for (int i = 0; i < 4; i++) begin
      if (inuse_q[i] && (age_q[i] != AGE_MAX)) age_d[i] = age_q[i] + 8'd1;
    end

    if (bus.resp_in != 2'd0) begin
      if (resp_hit) begin
        inuse_d[bus.resp_tag_in] = 1'b0;
        res_valid_d = 1'b1;
        res_resp_d  = bus.resp_in;
        res_data_d  = bus.resp_data_in;
        res_tag_d   = bus.resp_tag_in;
        res_cmd_d   = cmd_mem_q[bus.resp_tag_in];
      end else begin
        spurious_d = 1'b1;
      end
    end

    // Only one expiry is retired per cycle; the others wait saturated.
    if (exp_any) begin
      inuse_d[exp_tag] = 1'b0;
      tout_d           = 1'b1;
      tout_tag_d       = exp_tag;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          inuse_d[free_tag]   = 1'b1;
          cmd_mem_d[free_tag] = bus.op_cmd;
          age_d[free_tag]     = 8'd0;
          opb_d               = bus.op_b;
          req_cmd_d           = bus.op_cmd;
          req_data_d          = bus.op_a;
          req_tag_d           = free_tag;
          state_d             = OP2;
        end
      end
      OP2: begin
        req_data_d = opb_q;
        req_tag_d  = req_tag_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      inuse_q     <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        cmd_mem_q[i] <= 4'd0;
        age_q[i]     <= 8'd0;
      end
      opb_q       <= 32'd0;
      req_cmd_q   <= 4'd0;
      req_data_q  <= 32'd0;
      req_tag_q   <= 2'd0;
      res_valid_q <= 1'b0;
      res_resp_q  <= 2'd0;
      res_data_q  <= 32'd0;
      res_tag_q   <= 2'd0;
      res_cmd_q   <= 4'd0;
      spurious_q  <= 1'b0;
      tout_q      <= 1'b0;
      tout_tag_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      inuse_q     <= inuse_d;
      cmd_mem_q   <= cmd_mem_d;
      age_q       <= age_d;
      opb_q       <= opb_d;
      req_cmd_q   <= req_cmd_d;
      req_data_q  <= req_data_d;
      req_tag_q   <= req_tag_d;
      res_valid_q <= res_valid_d;
      res_resp_q  <= res_resp_d;
      res_data_q  <= res_data_d;
      res_tag_q   <= res_tag_d;
      res_cmd_q   <= res_cmd_d;
      spurious_q  <= spurious_d;
      tout_q      <= tout_d;
      tout_tag_q  <= tout_tag_d;
    end
  end

  assign bus.op_ready     = ready;
  assign bus.req_cmd_out  = req_cmd_q;
  assign bus.req_data_out = req_data_q;
  assign bus.req_tag_out  = req_tag_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_resp     = res_resp_q;
  assign bus.res_data     = res_data_q;
  assign bus.res_tag      = res_tag_q;
  assign bus.res_cmd      = res_cmd_q;
  assign bus.spurious_err = spurious_q;
  assign bus.timeout_err  = tout_q;
  assign bus.timeout_tag  = tout_tag_q;
  assign bus.busy_tags    = inuse_q;
endmodule
`default_nettype wire
